// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI master transmitter.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    SETUP,
    SHIFT,
    HOLD
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CLK_DIV    = 4;
  localparam int DEF_CS_HOLD    = 2;

  // {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;

endpackage

// File: rtl/spi_clk_div.sv
// SCLK generator: toggles sclk every CLK_DIV cycles while run is high and
// flags each rising/falling transition with a one-cycle strobe.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic rise_stb,
  output logic fall_stb,
  output logic sclk
);

  localparam int                CNT_W     = $clog2(CLK_DIV) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic              SCLK_IDLE = SPI_MODE0[1];

  logic [CNT_W-1:0] cnt_q;
  logic             sclk_q;
  logic             term;

  assign term     = run && (cnt_q == CNT_LAST);
  assign rise_stb = term && (sclk_q == SCLK_IDLE);
  assign fall_stb = term && (sclk_q != SCLK_IDLE);
  assign sclk     = sclk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sclk_q <= SCLK_IDLE;
    end else if (!run) begin
      cnt_q  <= '0;
      sclk_q <= SCLK_IDLE;
    end else if (term) begin
      cnt_q  <= '0;
      sclk_q <= ~sclk_q;
    end else begin
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 master: pops FIFO bytes, shifts them out on mosi and captures miso.
// Define SPI_LSB_FIRST_EN to transmit and receive LSB first.
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int CS_HOLD    = DEF_CS_HOLD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs_n,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy
);

  localparam int               BIT_W      = $clog2(DATA_WIDTH) + 1;
  localparam int               WAIT_MAX   = (CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD;
  localparam int               WAIT_W     = $clog2(WAIT_MAX) + 1;
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_WIDTH - 1);
  localparam logic [WAIT_W-1:0] SETUP_LAST = WAIT_W'(CLK_DIV - 1);
  localparam logic [WAIT_W-1:0] HOLD_LAST  = WAIT_W'(CS_HOLD - 1);

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
`ifdef SPI_LSB_FIRST_EN
    return w[0];
`else
    return w[DATA_WIDTH-1];
`endif
  endfunction

  function automatic logic [DATA_WIDTH-1:0] tx_shift(input logic [DATA_WIDTH-1:0] w);
`ifdef SPI_LSB_FIRST_EN
    return {1'b0, w[DATA_WIDTH-1:1]};
`else
    return {w[DATA_WIDTH-2:0], 1'b0};
`endif
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rx_shift(input logic [DATA_WIDTH-1:0] w,
                                                      input logic b);
`ifdef SPI_LSB_FIRST_EN
    return {b, w[DATA_WIDTH-1:1]};
`else
    return {w[DATA_WIDTH-2:0], b};
`endif
  endfunction

  state_t                state_q, state_d;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic                  rise_stb;
  logic                  fall_stb;
  logic                  byte_done;
  logic                  more;

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (state_q == SHIFT),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb),
    .sclk     (sclk)
  );

  assign more = enable && !fifo_empty;
  assign cs_n = (state_q == IDLE);
  assign busy = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    fifo_rd_en = 1'b0;
    byte_done  = 1'b0;
    case (state_q)
      IDLE:  if (more) state_d = POP;
      POP: begin
        fifo_rd_en = 1'b1;
        state_d    = LOAD;
      end
      LOAD:  state_d = SETUP;
      SETUP: if (wait_cnt == SETUP_LAST) state_d = SHIFT;
      SHIFT: begin
        if (fall_stb && (bit_cnt == LAST_BIT)) begin
          byte_done = 1'b1;
          // Back-to-back bytes skip HOLD so cs_n stays low across the burst.
          if (more)              state_d = POP;
          else if (CS_HOLD == 0) state_d = IDLE;
          else                   state_d = HOLD;
        end
      end
      HOLD:    if (wait_cnt == HOLD_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wait_cnt <= '0;
      bit_cnt  <= '0;
      mosi     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      state_q  <= state_d;
      rx_valid <= byte_done;
      if ((state_d == state_q) && ((state_q == SETUP) || (state_q == HOLD)))
        wait_cnt <= wait_cnt + WAIT_W'(1);
      else
        wait_cnt <= '0;
      if (state_q == LOAD)
        bit_cnt <= '0;
      else if (fall_stb)
        bit_cnt <= bit_cnt + BIT_W'(1);
      if (state_q == LOAD)
        mosi <= first_bit(fifo_dout);
      else if (fall_stb)
        mosi <= first_bit(tx_shift(tx_sr));
      if (byte_done)
        rx_data <= rx_sr;
    end
  end

  // Shift registers carry data only; every bit is rewritten before it is used.
  always_ff @(posedge clk) begin
    if (state_q == LOAD)
      tx_sr <= fifo_dout;
    else if (fall_stb)
      tx_sr <= tx_shift(tx_sr);
    if (rise_stb)
      rx_sr <= rx_shift(rx_sr, miso);
  end

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx with a loopback slave and a simple FIFO model.
module tb_spi_master_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_dout = 8'h00;
  logic       sclk, mosi, miso, cs_n, rx_valid, busy;
  logic [7:0] rx_data;

  logic [7:0] mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int rises = 0;
  int cs_rises = 0;
  int rx_n = 0;
  int empty_rd = 0;
  logic [7:0] mosi_cap = 8'h00;

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign miso       = mosi;

  spi_master_tx #(
    .DATA_WIDTH (8),
    .CLK_DIV    (4),
    .CS_HOLD    (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .sclk       (sclk),
    .mosi       (mosi),
    .miso       (miso),
    .cs_n       (cs_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .busy       (busy)
  );

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_dout <= mem[rd_ptr % 16];
      rd_ptr    <= rd_ptr + 1;
      pops      <= pops + 1;
      if (fifo_empty) empty_rd <= empty_rd + 1;
    end
  end

  always @(posedge sclk) begin
    mosi_cap <= {mosi_cap[6:0], mosi};
    rises    <= rises + 1;
  end

  always @(posedge cs_n) cs_rises <= cs_rises + 1;

  always @(negedge clk) if (rx_valid) rx_n <= rx_n + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 16] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_rx(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (rx_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_rises(input int base, input int count, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rises - base >= count) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int n, p0, r0, c0, s0;
    bit ok, bad;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte 0xA5
    p0 = pops;
    push(8'hA5);
    enable = 1'b1;
    wait_rx(200, n);
    check("t1_latency", n, 32'd71);
    check("t1_rx_data", 32'(rx_data), 32'hA5);
    check("t1_mosi_bits", 32'(mosi_cap), 32'hA5);
    check("t1_cs_low", 32'(cs_n), 32'd0);
    check("t1_pops", pops - p0, 32'd1);
    @(negedge clk);
    check("t1_hold_cs", 32'(cs_n), 32'd0);
    check("t1_rx_pulse", 32'(rx_valid), 32'd0);
    @(negedge clk);
    check("t1_cs_release", 32'(cs_n), 32'd1);
    check("t1_busy_idle", 32'(busy), 32'd0);

    // Back-to-back 0x3C, 0xC3
    p0 = pops; c0 = cs_rises; r0 = rx_n;
    push(8'h3C);
    push(8'hC3);
    wait_rx(200, n);
    check("t2_latency1", n, 32'd71);
    check("t2_rx_data1", 32'(rx_data), 32'h3C);
    check("t2_mosi_bits1", 32'(mosi_cap), 32'h3C);
    @(negedge clk);
    check("t2_rx_pulse", 32'(rx_valid), 32'd0);
    check("t2_gap_cs", 32'(cs_n), 32'd0);
    wait_rx(200, n);
    check("t2_latency2", n, 32'd69);
    check("t2_rx_data2", 32'(rx_data), 32'hC3);
    check("t2_mosi_bits2", 32'(mosi_cap), 32'hC3);
    check("t2_cs_no_rise", cs_rises - c0, 32'd0);
    check("t2_pops", pops - p0, 32'd2);
    repeat (3) @(negedge clk);
    check("t2_cs_release", 32'(cs_n), 32'd1);
    check("t2_rx_count", rx_n - r0, 32'd2);

    // Empty FIFO with enable high
    p0 = pops; bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (fifo_rd_en || !cs_n || sclk || busy) bad = 1'b1;
    end
    check("t3_idle_quiet", 32'(bad), 32'd0);
    check("t3_pops", pops - p0, 32'd0);

    // enable dropped at the 3rd rising edge of 0x55
    p0 = pops; s0 = rises;
    push(8'h55);
    push(8'h99);
    wait_rises(s0, 3, ok);
    check("t4_reach_rise3", 32'(ok), 32'd1);
    enable = 1'b0;
    wait_rx(200, n);
    check("t4_latency", n, 32'd44);
    check("t4_rx_data", 32'(rx_data), 32'h55);
    check("t4_mosi_bits", 32'(mosi_cap), 32'h55);
    repeat (4) @(negedge clk);
    check("t4_cs_release", 32'(cs_n), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_pops", pops - p0, 32'd1);
    check("t4_fifo_left", 32'(fifo_empty), 32'd0);

    // Reset pulse during the 5th bit of 0x99
    r0 = rx_n; s0 = rises;
    enable = 1'b1;
    wait_rises(s0, 5, ok);
    check("t5_reach_rise5", 32'(ok), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_sclk", 32'(sclk), 32'd0);
    check("t5_rst_cs_n", 32'(cs_n), 32'd1);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_rx_data", 32'(rx_data), 32'd0);
    repeat (2) @(negedge clk);
    check("t5_rst_rx_valid", 32'(rx_valid), 32'd0);
    push(8'h6B);
    rst_n = 1'b1;
    wait_rx(200, n);
    check("t5_latency", n, 32'd71);
    check("t5_rx_data", 32'(rx_data), 32'h6B);
    check("t5_mosi_bits", 32'(mosi_cap), 32'h6B);
    repeat (4) @(negedge clk);
    check("t5_rx_count", rx_n - r0, 32'd1);

    // Single set bit shows the transmit order
    push(8'h01);
    wait_rx(200, n);
    check("t6_latency", n, 32'd71);
    check("t6_rx_data", 32'(rx_data), 32'h01);
`ifdef SPI_LSB_FIRST_EN
    check("t6_mosi_order", 32'(mosi_cap), 32'h80);
`else
    check("t6_mosi_order", 32'(mosi_cap), 32'h01);
`endif
    repeat (4) @(negedge clk);
    check("rd_while_empty", empty_rd, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_tx.md
Name: spi_master_tx

Overview:
- Downstream consumer of the asynchronous FIFO's read side in the AHB-Lite to SPI bridge.
- Runs entirely in the FIFO read-clock domain.
- Pops bytes from the FIFO, serialises them on SPI mode 0 (CPOL=0, CPHA=0), and captures MISO into a received-byte register.
- Keeps CS asserted across back-to-back bytes while the FIFO stays non-empty.

Parameters:
- DATA_WIDTH, 8: width of each SPI word; equals the FIFO word width.
- CLK_DIV, 4: SCLK half-period in clk cycles; legal range >= 1.
- CS_HOLD, 2: clk cycles cs_n stays low after the last falling SCLK edge of a burst.

Ports:
- clk  in  1  clock; same clock as the FIFO read clock.
- rst_n  in  1  reset; asynchronous, active-low.
- enable  in  1  permits starting or continuing a burst.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read request; one-cycle pulse per byte.
- fifo_dout  in  DATA_WIDTH  FIFO registered read data; valid the cycle after fifo_rd_en.
- sclk  out  1  SPI clock; idles low.
- mosi  out  1  SPI data out.
- miso  in  1  SPI data in.
- cs_n  out  1  chip select, active-low.
- rx_data  out  DATA_WIDTH  last byte received from MISO.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst_n=0) takes effect immediately, mid-transfer included. Outputs: sclk=0, cs_n=1, mosi=0, fifo_rd_en=0, rx_data=0, rx_valid=0, busy=0. State returns to IDLE; the in-flight byte is discarded.
- IDLE:
  - If enable && !fifo_empty, go to POP.
  - Otherwise stay.
- POP (1 cycle): fifo_rd_en=1; cs_n=0.
- LOAD (1 cycle): shift register <= fifo_dout.
- SETUP (CLK_DIV cycles): mosi = bit DATA_WIDTH-1; sclk=0.
- SHIFT:
  - Divider counter counts 0..CLK_DIV-1; sclk toggles on the terminal count.
  - Rising edge: sample miso into the receive shift register LSB.
  - Falling edge: shift; mosi presents the next bit.
  - Bit order is MSB first.
  - Duration is 2*DATA_WIDTH*CLK_DIV cycles; the byte ends on the DATA_WIDTH-th falling edge.
- End of byte (cycle after the last falling edge):
  - rx_data <= received byte; rx_valid=1 for one cycle.
  - If enable && !fifo_empty: go to POP with cs_n held low (back-to-back). The inter-byte gap is 2+CLK_DIV cycles with sclk low.
  - Otherwise go to HOLD.
- HOLD (CS_HOLD cycles): cs_n stays 0, then cs_n=1 and state goes to IDLE.
- enable dropping mid-byte: the current byte completes fully, then the block goes to HOLD.
- fifo_rd_en:
  - Never asserted while fifo_empty=1.
  - At most one pulse per byte.
- Counters:
  - Divider width is clog2(CLK_DIV)+1.
  - Bit counter width is clog2(DATA_WIDTH)+1.
  - Both wrap to 0 at the start of each byte.
- cs_n never toggles inside a byte. sclk is 0 whenever cs_n=1.

Optional Feature:
- Macro: SPI_LSB_FIRST_EN.
- Defined: bits transmit LSB first. SETUP presents bit 0, and received bits shift in from the MSB side, so rx_data is bit-order-correct.
- Undefined: MSB first, as described under Behaviour.
- Timing is identical in both builds.

Decomposition:
- Package spi_pkg holds:
  - state enum: IDLE, POP, LOAD, SETUP, SHIFT, HOLD.
  - default constants for DATA_WIDTH, CLK_DIV, CS_HOLD.
  - SPI_MODE0 constant.
- Sub-module spi_clk_div:
  - Inputs: run enable.
  - Outputs: one-cycle rise_stb and fall_stb strobes, plus sclk.
  - Resets its count when run=0.
  - The FSM consumes only the strobes.

Test Plan:
- Single byte, CLK_DIV=4: FIFO holds 0xA5, enable=1.
  - One fifo_rd_en pulse; mosi bits 1,0,1,0,0,1,0,1 across 8 SCLK periods of 8 clk each.
  - cs_n low CS_HOLD=2 cycles after the last falling edge, then high.
- Loopback miso=mosi, bytes 0x3C then 0xC3 back-to-back:
  - cs_n stays low throughout; gap between bytes is 6 clk.
  - rx_valid pulses twice with rx_data 0x3C then 0xC3.
- FIFO empty with enable=1: no fifo_rd_en, cs_n=1, sclk=0, busy=0 for 100 cycles.
- enable deasserted at the 3rd rising edge of byte 0x55, FIFO non-empty:
  - Byte completes and rx_valid pulses.
  - No further pop; cs_n returns high.
- rst_n pulsed low during the 5th bit: immediately sclk=0, cs_n=1, busy=0; no rx_valid. After release, the next FIFO byte transmits normally.
- SPI_LSB_FIRST_EN defined, byte 0x01, loopback: mosi high on the first bit only; rx_data=0x01.
